// File: rtl/cp0_count_timer_pkg.sv
// Shared constants for the CP0 Count/Compare timer units: read filler,
// register numbers, timer interrupt bit and default prescaler ratio.
package cp0_count_timer_pkg;

    localparam logic [63:0] UNKNOW            = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int unsigned CP0_REG_COUNT     = 9;
    localparam int unsigned CP0_REG_COMPARE   = 11;
    localparam int unsigned TIMER_IP_BIT      = 7;
    localparam int unsigned COUNT_DIV_DEFAULT = 2;

    // A DIV of 1 still needs a one-bit prescaler register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/cp0_prescaler.sv
// Divides the core clock by DIV; emits a one-cycle tick on the last phase.
// clr restarts the phase at zero, stall freezes it.
module cp0_prescaler
    import cp0_count_timer_pkg::*;
#(
    parameter int unsigned DIV = COUNT_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic stall,
    output logic tick
);

    localparam int unsigned     PW   = presc_width(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] pres_q;
    logic [PW-1:0] pres_d;

    always_comb begin
        tick   = 1'b0;
        pres_d = pres_q;
        if (clr) begin
            pres_d = '0;
        end else if (!stall) begin
            if (pres_q == LAST) begin
                tick   = 1'b1;
                pres_d = '0;
            end else begin
                pres_d = pres_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pres_q <= '0;
        end else begin
            pres_q <= pres_d;
        end
    end

endmodule

// File: rtl/cp0_count_timer.sv
// CP0 Count register with Compare-match timer interrupt (Cause.IP7).
// Optional macro CP0_COUNT_DC_EN adds the Cause.DC input that freezes counting.
module cp0_count_timer
    import cp0_count_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIV   = COUNT_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_p,
    input  logic             r_h,
    input  logic             we_s,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] compare,
    input  logic             compare_we,
`ifdef CP0_COUNT_DC_EN
    input  logic             dc,
`endif
    output logic             timer_int
);

    logic             stall;
    logic             tick;
    logic             match;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             match_q;
    logic             match_d;
    logic             timer_int_q;
    logic             timer_int_d;

`ifdef CP0_COUNT_DC_EN
    assign stall = dc;
`else
    assign stall = 1'b0;
`endif

    cp0_prescaler #(
        .DIV   (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (we_s),
        .stall (stall),
        .tick  (tick)
    );

    assign match = (count_q == compare);

    always_comb begin
        count_d = count_q;
        if (we_s) begin
            count_d = write_data;
        end else if (tick) begin
            count_d = count_q + 1'b1;
        end
    end

    // A Compare write supersedes any match edge seen in the same cycle.
    always_comb begin
        match_d     = match;
        timer_int_d = timer_int_q;
        if (compare_we) begin
            timer_int_d = 1'b0;
        end else if (match && !match_q) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            match_q     <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            match_q     <= match_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign read_data = (r_p || r_h) ? count_q : UNKNOW[WIDTH-1:0];
    assign timer_int = timer_int_q;

endmodule

// File: tb/tb_cp0_count_timer.sv
// Bench for cp0_count_timer: a DIV=2 and a DIV=1 instance share one stimulus
// and are checked each cycle against an anchor-based Count/interrupt model.
module tb_cp0_count_timer;

    localparam logic [31:0] FILL = 32'hDEAD_BEEF;
    localparam int MDIV [2] = '{2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_p = 1'b0;
    logic        r_h = 1'b0;
    logic        we_s = 1'b0;
    logic        compare_we = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] compare = '0;
    logic [31:0] rd_a, rd_b;
    logic        ti_a, ti_b;

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0]     m_base [2];
    longint unsigned m_cyc  [2];
    bit              m_prev [2];
    bit              m_ti   [2];

    bit          seen_a, seen_b;
    logic [31:0] at_a, at_b;
    logic [31:0] seq_a [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};

    always #5 clk = ~clk;

    cp0_count_timer #(.WIDTH(32), .DIV(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .r_p        (r_p),
        .r_h        (r_h),
        .we_s       (we_s),
        .write_data (write_data),
        .read_data  (rd_a),
        .compare    (compare),
        .compare_we (compare_we),
`ifdef CP0_COUNT_DC_EN
        .dc         (1'b0),
`endif
        .timer_int  (ti_a)
    );

    cp0_count_timer #(.WIDTH(32), .DIV(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .r_p        (r_p),
        .r_h        (r_h),
        .we_s       (we_s),
        .write_data (write_data),
        .read_data  (rd_b),
        .compare    (compare),
        .compare_we (compare_we),
`ifdef CP0_COUNT_DC_EN
        .dc         (1'b0),
`endif
        .timer_int  (ti_b)
    );

    // Count is the last written value plus whole DIV periods elapsed since.
    function automatic logic [31:0] m_count(input int i);
        return m_base[i] + 32'(m_cyc[i] / 64'(MDIV[i]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_base[i] <= '0;
                m_cyc[i]  <= 0;
                m_prev[i] <= 1'b0;
                m_ti[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (we_s) begin
                    m_base[i] <= write_data;
                    m_cyc[i]  <= 0;
                end else begin
                    m_cyc[i] <= m_cyc[i] + 1;
                end
                m_ti[i]   <= compare_we ? 1'b0 :
                             ((m_count(i) == compare) && !m_prev[i]) ? 1'b1 : m_ti[i];
                m_prev[i] <= (m_count(i) == compare);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model_rd_a", rd_a, (r_p || r_h) ? m_count(0) : FILL);
            check("model_ti_a", 32'(ti_a), 32'(m_ti[0]));
            check("model_rd_b", rd_b, (r_p || r_h) ? m_count(1) : FILL);
            check("model_ti_b", 32'(ti_b), 32'(m_ti[1]));
        end
    end

    initial begin
        compare = 32'hFFFF_0000;
        r_p = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_cnt_a0", rd_a, seq_a[0]);
        check("reset_cnt_b0", rd_b, 32'd0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("reset_cnt_a", rd_a, seq_a[k]);
            check("reset_cnt_b", rd_b, 32'(k));
            check("reset_ti_a", 32'(ti_a), 32'd0);
        end

        // Match: Count written to 0x10, Compare 0x12, read via hardware port
        #1 we_s = 1'b1; write_data = 32'h10; compare = 32'h12; compare_we = 1'b1;
        r_p = 1'b0; r_h = 1'b1;
        @(negedge clk);
        check("match_wr_a", rd_a, 32'h10);
        check("match_wr_b", rd_b, 32'h10);
        #1 we_s = 1'b0; compare_we = 1'b0;
        @(negedge clk);
        check("match_hold_a", rd_a, 32'h10);
        @(negedge clk);
        check("match_eq_b", rd_b, 32'h12);
        check("match_pre_b", 32'(ti_b), 32'd0);
        @(negedge clk);
        check("match_set_b", 32'(ti_b), 32'd1);
        @(negedge clk);
        check("match_eq_a", rd_a, 32'h12);
        check("match_pre_a", 32'(ti_a), 32'd0);
        @(negedge clk);
        check("match_set_a", 32'(ti_a), 32'd1);
        check("match_cnt_a", rd_a, 32'h12);
        repeat (5) @(negedge clk);
        check("match_hold_ti_a", 32'(ti_a), 32'd1);

        // Clear by Compare write, reassert when Count reaches 0x100
        #1 compare = 32'h100; compare_we = 1'b1; r_h = 1'b0; r_p = 1'b1;
        @(negedge clk);
        check("clear_a", 32'(ti_a), 32'd0);
        check("clear_b", 32'(ti_b), 32'd0);
        #1 compare_we = 1'b0;
        seen_a = 1'b0; seen_b = 1'b0; at_a = '0; at_b = '0;
        for (int n = 0; n < 700 && !(seen_a && seen_b); n++) begin
            @(negedge clk);
            if (!seen_a && ti_a) begin seen_a = 1'b1; at_a = rd_a; end
            if (!seen_b && ti_b) begin seen_b = 1'b1; at_b = rd_b; end
        end
        check("reassert_seen_a", 32'(seen_a), 32'd1);
        check("reassert_cnt_a", at_a, 32'h100);
        check("reassert_seen_b", 32'(seen_b), 32'd1);
        check("reassert_cnt_b", at_b, 32'h101);

        // Simultaneous: match edge and Compare write in the same cycle
        #1 we_s = 1'b1; write_data = 32'h400; compare = 32'h400; compare_we = 1'b1; r_p = 1'b0;
        @(negedge clk);
        check("simul_wr_ti_a", 32'(ti_a), 32'd0);
        check("simul_wr_ti_b", 32'(ti_b), 32'd0);
        #1 we_s = 1'b0;
        @(negedge clk);
        check("simul_ti_a", 32'(ti_a), 32'd0);
        check("simul_ti_b", 32'(ti_b), 32'd0);
        #1 compare_we = 1'b0; compare = 32'h500;
        @(negedge clk);
        check("simul_after_a", 32'(ti_a), 32'd0);
        check("simul_after_b", 32'(ti_b), 32'd0);
        check("fill_a", rd_a, FILL);

        // Wrap through 0xFFFF_FFFF with Compare = 0
        #1 we_s = 1'b1; write_data = 32'hFFFF_FFFE; compare = 32'h0; compare_we = 1'b1; r_p = 1'b1;
        @(negedge clk);
        check("wrap_wr_b", rd_b, 32'hFFFF_FFFE);
        #1 we_s = 1'b0; compare_we = 1'b0;
        @(negedge clk);
        check("wrap_max_b", rd_b, 32'hFFFF_FFFF);
        check("wrap_hold_a", rd_a, 32'hFFFF_FFFE);
        @(negedge clk);
        check("wrap_zero_b", rd_b, 32'h0);
        check("wrap_pre_b", 32'(ti_b), 32'd0);
        check("wrap_max_a", rd_a, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_set_b", 32'(ti_b), 32'd1);
        @(negedge clk);
        check("wrap_zero_a", rd_a, 32'h0);
        check("wrap_pre_a", 32'(ti_a), 32'd0);
        @(negedge clk);
        check("wrap_set_a", 32'(ti_a), 32'd1);

        // Async reset mid-run at count 0x55 with interrupt pending
        #1 we_s = 1'b1; write_data = 32'h55; compare = 32'h55; compare_we = 1'b1;
        @(negedge clk);
        check("rst_pre_cnt_a", rd_a, 32'h55);
        #1 we_s = 1'b0; compare_we = 1'b0;
        @(negedge clk);
        check("rst_pre_ti_a", 32'(ti_a), 32'd1);
        check("rst_pre_ti_b", 32'(ti_b), 32'd1);
        check("rst_pre_cnt_a2", rd_a, 32'h55);
        #1 r_p = 1'b0; r_h = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_fill_a", rd_a, FILL);
        check("rst_ti_a", 32'(ti_a), 32'd0);
        check("rst_ti_b", 32'(ti_b), 32'd0);
        r_p = 1'b1;
        #1;
        check("rst_cnt_a", rd_a, 32'h0);
        check("rst_cnt_b", rd_b, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("restart_cnt_a", rd_a, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
